if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory, word-aligned.
REQ-006 SHALL have port imem_instr  input  32  combinational read data from instruction memory.
REQ-007 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 32), branch/jump target request.
REQ-008 SHALL have ports halt_req (input, 1) and resume (input, 1), fetch halt/restart controls.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_pc (output, 32), out_instr (output, 32), fetch-to-decode handshake.
REQ-010 SHALL have port halted  output  1  high while the FSM is in HALTED.

Function
REQ-011 SHALL drive imem_addr combinationally from the internal pc register.
REQ-012 SHALL implement FSM states BOOT, RUN, HALTED; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-013 In RUN, advance SHALL occur when !out_valid || out_ready: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-014 SHALL sustain one instruction per cycle with out_ready held high; latency pc-to-out_instr is one cycle.
REQ-015 When out_valid && !out_ready, out_pc, out_instr, out_valid and pc SHALL hold stable.
REQ-016 out_valid && out_ready with no new advance (HALTED, BOOT) SHALL clear out_valid next cycle.
REQ-017 redirect_valid SHALL take priority over stall and advance: pc<=redirect_pc (bits [1:0] forced 0), out_valid<=0 next cycle.
REQ-018 A redirect in BOOT or HALTED SHALL update pc only, without state change.
REQ-019 halt_req in RUN SHALL move the FSM to HALTED next cycle; the advance in that same cycle still occurs.
REQ-020 In HALTED, pc SHALL freeze; a pending out_valid SHALL remain until handshaken.
REQ-021 resume in HALTED SHALL return to RUN next cycle; halt_req and resume together SHALL keep the current state.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Fetch beyond IMEM_WORDS SHALL proceed normally; the returned word is passed through unmodified.

Reset
REQ-024 On rst_n low at a clock edge: pc=RESET_PC, FSM=BOOT, out_valid=0, out_pc=0, out_instr=32'h0000_0013, halted=0.
REQ-025 Reset mid-operation SHALL discard any pending output and redirect with no residual effect.

Configuration
REQ-026 With FETCH_MISALIGN_TRAP_EN defined, a redirect_pc with bits [1:0]!=0 SHALL be ignored, enter HALTED, and set output misalign_err (1 bit), cleared only by reset.
REQ-027 Without FETCH_MISALIGN_TRAP_EN, misalign_err SHALL not exist and REQ-017 masking applies.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, NOP_INSTR=32'h0000_0013 and the PC increment constant 4.
REQ-029 A single sub-module if_pc_reg (pc register with advance/redirect/hold mux) SHALL be instantiated; the FSM and output register stay in if_stage.

Verification
REQ-030 Reset, memory words 0x00500093, 0x00A00113, 0x002081B3, out_ready=1 -> out_pc 0,4,8 carry those words on consecutive cycles after BOOT.
REQ-031 out_ready low for 3 cycles at out_pc=4 -> out_pc=4/out_instr=0x00A00113 held; pc stays 8; resumes at 8.
REQ-032 redirect_valid with redirect_pc=0x40 while stalled -> out_valid=0 next cycle, then out_pc=0x40.
REQ-033 halt_req at out_pc=8 -> halted=1, no new out_valid; resume -> next out_pc=0xC.
REQ-034 redirect_pc=0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x0.
REQ-035 With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x42 -> misalign_err=1, halted=1, pc unchanged; without it, out_pc=0x40.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: fetch FSM state enum, NOP instruction encoding, PC increment,
// PC alignment mask and a helper that word-aligns a byte address.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [31:0] PC_INCR       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Force the two byte-offset bits of a fetch address to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register for the fetch stage.
// Priority: redirect (word-aligned target) > advance (pc + 4, wraps) > hold.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset, loads RESET_PC
//   redirect    - load the aligned redirect_pc
//   redirect_pc - redirect target byte address
//   advance     - step to the next sequential word
//   pc          - current fetch address
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    // PC update: redirect wins over sequential advance; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= align_pc(redirect_pc);
        end else if (advance) begin
            pc <= pc + PC_INCR;
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/RUN/HALTED FSM, PC register and a one-entry
// valid/ready output register towards decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a redirect whose target
// has non-zero bits [1:0] is dropped, the FSM halts and misalign_err latches
// until reset. Without it, redirect targets are simply word-aligned.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   imem_addr / imem_instr      - instruction memory address and read data
//   redirect_valid/redirect_pc  - branch/jump target request
//   halt_req / resume           - stop and restart fetching
//   out_valid/out_ready/out_pc/out_instr - handshake to decode
//   halted                      - FSM is in HALTED
//   misalign_err                - (trap build only) misaligned redirect seen
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    // Addresses beyond the memory depth are still fetched; the depth only
    // has to be sane.
    if (IMEM_WORDS < 1) begin : g_depth_check
        $error("if_stage: IMEM_WORDS must be at least 1");
    end

    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [31:0]  pc_s;
    logic         redirect_ok_s;
    logic         advance_s;
    logic         out_valid_r;
    logic [31:0]  out_pc_r;
    logic [31:0]  out_instr_r;
    logic         halted_r;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic         misalign_s;
    logic         misalign_err_r;

    assign misalign_s    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_ok_s = redirect_valid && !misalign_s;
`else
    assign redirect_ok_s = redirect_valid;
`endif

    // Any redirect request (even a dropped misaligned one) suppresses the
    // sequential advance, so a trapped redirect leaves the pc untouched.
    assign advance_s = (state_r == ST_RUN) && (!out_valid_r || out_ready) && !redirect_valid;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect_ok_s),
        .redirect_pc (redirect_pc),
        .advance     (advance_s),
        .pc          (pc_s)
    );

    assign imem_addr = pc_s;

    // Next-state logic; halt_req together with resume keeps the current state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_BOOT: begin
                next_state_s = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req && !resume) begin
                    next_state_s = ST_HALTED;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume && !halt_req) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_HALTED;
                end
            end
            default: begin
                next_state_s = ST_BOOT;
            end
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign_s) begin
            next_state_s = ST_HALTED;
        end else begin
            next_state_s = next_state_s;
        end
`endif
    end

    // FSM state register and registered halted flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_BOOT;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == ST_HALTED);
        end
    end

    // Output register: a RUN redirect flushes, an advance loads, a handshake
    // without a new fetch empties, anything else holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'h0000_0000;
            out_instr_r <= NOP_INSTR;
        end else if (redirect_ok_s && (state_r == ST_RUN)) begin
            out_valid_r <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= 1'b1;
            out_pc_r    <= pc_s;
            out_instr_r <= imem_instr;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misalignment error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_err_r <= 1'b0;
        end else if (misalign_s) begin
            misalign_err_r <= 1'b1;
        end else begin
            misalign_err_r <= misalign_err_r;
        end
    end

    assign misalign_err = misalign_err_r;
`endif

    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_instr = out_instr_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: sequential fetch, stall,
// redirect, halt/resume, PC wrap and misaligned redirect handling.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic [31:0] saved_addr;

    assign imem_instr = mem[imem_addr[7:2]];

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA000_0000 | 32'(i);
        end
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        halt_req       = 1'b0;
        resume         = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0000_0000);
        check("rst_instr", out_instr, 32'h0000_0013);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);

        // BOOT lasts one cycle, then sequential fetch
        rst_n = 1'b1;
        step();
        check("boot_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("f0_valid", {31'd0, out_valid}, 32'd1);
        check("f0_pc", out_pc, 32'h0000_0000);
        check("f0_instr", out_instr, 32'h0050_0093);
        step();
        check("f1_pc", out_pc, 32'h0000_0004);
        check("f1_instr", out_instr, 32'h00A0_0113);

        // Stall for three cycles at out_pc = 4
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pc", out_pc, 32'h0000_0004);
            check("stall_instr", out_instr, 32'h00A0_0113);
            check("stall_addr", imem_addr, 32'h0000_0008);
        end
        out_ready = 1'b1;
        step();
        check("f2_pc", out_pc, 32'h0000_0008);
        check("f2_instr", out_instr, 32'h0020_81B3);
        step();
        check("f3_pc", out_pc, 32'h0000_000C);

        // Redirect while stalled
        out_ready = 1'b0;
        step();
        check("stall2_pc", out_pc, 32'h0000_000C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        check("redir_valid", {31'd0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h0000_0040);
        redirect_valid = 1'b0;
        step();
        check("redir_out_pc", out_pc, 32'h0000_0040);
        check("redir_out_instr", out_instr, 32'hA000_0010);
        out_ready = 1'b1;

        // Reset mid-operation discards the pending output
        rst_n = 1'b0;
        step();
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_pc", out_pc, 32'h0000_0000);
        check("rst2_instr", out_instr, 32'h0000_0013);
        check("rst2_addr", imem_addr, 32'h0000_0000);
        rst_n = 1'b1;
        step();
        step();
        check("r_f0_pc", out_pc, 32'h0000_0000);
        step();
        check("r_f1_pc", out_pc, 32'h0000_0004);

        // Halt: the advance in the halt_req cycle still happens
        halt_req = 1'b1;
        step();
        check("halt_pc", out_pc, 32'h0000_0008);
        check("halt_valid", {31'd0, out_valid}, 32'd1);
        check("halt_flag", {31'd0, halted}, 32'd1);
        halt_req = 1'b0;
        step();
        check("halted_drain", {31'd0, out_valid}, 32'd0);
        check("halted_addr", imem_addr, 32'h0000_000C);
        halt_req = 1'b1;
        resume   = 1'b1;
        step();
        check("both_halted", {31'd0, halted}, 32'd1);
        check("both_valid", {31'd0, out_valid}, 32'd0);
        halt_req = 1'b0;
        step();
        check("resume_flag", {31'd0, halted}, 32'd0);
        check("resume_valid", {31'd0, out_valid}, 32'd0);
        resume = 1'b0;
        step();
        check("resume_pc", out_pc, 32'h0000_000C);
        check("resume_instr", out_instr, 32'hA000_0003);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        check("wrap_redir_valid", {31'd0, out_valid}, 32'd0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", out_instr, 32'hA000_003F);
        step();
        check("wrap_pc_zero", out_pc, 32'h0000_0000);
        check("wrap_instr_zero", out_instr, 32'h0050_0093);
        check("wrap_addr_next", imem_addr, 32'h0000_0004);

        // Misaligned redirect
        saved_addr     = imem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_addr", imem_addr, saved_addr);
        redirect_valid = 1'b0;
        step();
        check("mis_err_sticky", {31'd0, misalign_err}, 32'd1);
        check("mis_still_halted", {31'd0, halted}, 32'd1);
`else
        check("mis_addr", imem_addr, 32'h0000_0040);
        check("mis_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check("mis_out_pc", out_pc, 32'h0000_0040);
        check("mis_out_instr", out_instr, 32'hA000_0010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
